// File: rtl/et_peak_finder_if.sv
// rtl/et_peak_finder_if.sv - ET/veto sample stream bundle for et_peak_finder
interface et_peak_finder_if;
    logic [15:0] et_sum;
    logic [15:0] veto_in;
    logic [16:0] et_out;
    logic [15:0] veto_out;

    modport master (
        output et_sum,
        output veto_in,
        input  et_out,
        input  veto_out
    );

    modport slave (
        input  et_sum,
        input  veto_in,
        output et_out,
        output veto_out
    );
endinterface

// File: rtl/et_peak_finder.sv
// rtl/et_peak_finder.sv - 3-tap ET local-maximum finder with hold-off
// Optional PEAK_CNT_EN adds cnt_clr/peak_cnt saturating peak counter.
module et_peak_finder #(
    parameter int HOLDOFF = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [15:0]        et_min,
`ifdef PEAK_CNT_EN
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   peak_cnt,
`endif
    output logic               busy,
    et_peak_finder_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    logic [15:0]      d0, d1, d2;
    logic [15:0]      v0, v1;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             above;
    logic             pk;

    // d1 is the candidate; d2 is older, d0 newer, so >= on d0 keeps only a plateau's first sample
    assign above = d1 > et_min;
    assign pk    = en && above && (d1 > d2) && (d1 >= d0) && (state != HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0           <= '0;
            d1           <= '0;
            d2           <= '0;
            v0           <= '0;
            v1           <= '0;
            bus.et_out   <= '0;
            bus.veto_out <= '0;
        end else begin
            d0           <= bus.et_sum;
            d1           <= d0;
            d2           <= d1;
            v0           <= bus.veto_in;
            v1           <= v0;
            bus.et_out   <= {pk, d1};
            bus.veto_out <= v1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == HOLD);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = above ? ARMED : IDLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    if (pk && (HOLDOFF > 0)) begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end else begin
                        state_nxt = above ? ARMED : IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PEAK_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_cnt <= '0;
        end else if (cnt_clr) begin
            peak_cnt <= '0;
        end else if (pk && (peak_cnt != '1)) begin
            peak_cnt <= peak_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_et_peak_finder.sv
// tb/tb_et_peak_finder.sv - randomized and directed bench for et_peak_finder
module tb_et_peak_finder;
    localparam int HOLDOFF = 8;
`ifdef PEAK_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] et_min;
    logic        busy;
`ifdef PEAK_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] peak_cnt;
    int               exp_cnt;
`endif

    et_peak_finder_if bus ();

    et_peak_finder #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .et_min  (et_min),
`ifdef PEAK_CNT_EN
        .cnt_clr (cnt_clr),
        .peak_cnt(peak_cnt),
`endif
        .busy    (busy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference history: one entry per clock edge since reset release
    logic [15:0] s_q[$];
    logic [15:0] v_q[$];
    int          last_pk;
    int          flags;
    int          busy_cycles;
    int          flag_edge;
    int          base;
    logic [16:0] flag_word;
    logic [15:0] flag_veto;
    int          seq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] samp(input int i);
        return (i < 0) ? 16'd0 : s_q[i];
    endfunction

    function automatic logic [15:0] vsamp(input int i);
        return (i < 0) ? 16'd0 : v_q[i];
    endfunction

    // A sample offered before edge n is judged at edge n+2 against its neighbours
    task automatic step(input logic [15:0] et, input logic [15:0] vt, input logic e);
        int          n;
        logic [15:0] newer, cand, older;
        logic        pk;
        bus.et_sum  = et;
        bus.veto_in = vt;
        en          = e;
        s_q.push_back(et);
        v_q.push_back(vt);
        n     = s_q.size() - 1;
        newer = samp(n - 1);
        cand  = samp(n - 2);
        older = samp(n - 3);
        pk = e && (cand > et_min) && (cand > older) && (cand >= newer) && (n - last_pk > HOLDOFF);
        if (!e) last_pk = -1000;
        if (pk) last_pk = n;
`ifdef PEAK_CNT_EN
        if (cnt_clr) exp_cnt = 0;
        else if (pk && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
        @(posedge clk);
        #1;
        chk("et_out", {15'd0, bus.et_out}, {15'd0, pk, cand});
        chk("veto_out", {16'd0, bus.veto_out}, {16'd0, vsamp(n - 2)});
        chk("busy", {31'd0, busy}, ((n - last_pk) < HOLDOFF) ? 32'd1 : 32'd0);
`ifdef PEAK_CNT_EN
        chk("peak_cnt", 32'(peak_cnt), 32'(exp_cnt));
`endif
        if (bus.et_out[16]) begin
            flags++;
            flag_word = bus.et_out;
            flag_veto = bus.veto_out;
            flag_edge = n;
        end
        if (busy) busy_cycles++;
    endtask

    task automatic run_seq(input logic [15:0] vt, input logic e, input int tail);
        foreach (seq[i]) step(16'(seq[i]), vt, e);
        for (int i = 0; i < tail; i++) step(16'd0, 16'd0, e);
    endtask

    task automatic start_test();
        flags       = 0;
        busy_cycles = 0;
        flag_edge   = -1;
        base        = s_q.size();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_et_out", {15'd0, bus.et_out}, 32'd0);
        chk("rst_veto_out", {16'd0, bus.veto_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef PEAK_CNT_EN
        chk("rst_peak_cnt", 32'(peak_cnt), 32'd0);
        exp_cnt = 0;
`endif
        s_q.delete();
        v_q.delete();
        last_pk = -1000;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        en          = 1'b0;
        et_min      = 16'd100;
        bus.et_sum  = '0;
        bus.veto_in = '0;
`ifdef PEAK_CNT_EN
        cnt_clr = 1'b0;
        exp_cnt = 0;
`endif
        last_pk = -1000;
        #2;
        do_reset();
        for (int i = 0; i < 4; i++) step(16'd0, 16'd0, 1'b1);

        // Single rising pulse
        start_test();
        seq = '{0, 50, 200, 300, 250, 0};
        run_seq(16'd0, 1'b1, 12);
        chk("t1_flags", 32'(flags), 32'd1);
        chk("t1_word", {15'd0, flag_word}, 32'h1012C);
        chk("t1_edge", 32'(flag_edge - base), 32'd5);

        // Plateau with veto tag on the plateau samples
        start_test();
        step(16'd0, 16'd0, 1'b1);
        step(16'd200, 16'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(16'd400, 16'hA5A5, 1'b1);
        step(16'd100, 16'd0, 1'b1);
        for (int i = 0; i < 12; i++) step(16'd0, 16'd0, 1'b1);
        chk("t2_flags", 32'(flags), 32'd1);
        chk("t2_word", {15'd0, flag_word}, 32'h10190);
        chk("t2_veto", {16'd0, flag_veto}, 32'hA5A5);

        // Second peak inside hold-off, then outside it
        start_test();
        seq = '{0, 500, 0, 0, 0, 0, 600, 0};
        run_seq(16'd0, 1'b1, 12);
        chk("t3_flags", 32'(flags), 32'd1);
        chk("t3_busy", 32'(busy_cycles), 32'd8);
        start_test();
        seq = '{0, 500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 600, 0};
        run_seq(16'd0, 1'b1, 12);
        chk("t3b_flags", 32'(flags), 32'd2);

        // Strict threshold compare
        start_test();
        seq = '{0, 100, 0};
        run_seq(16'd0, 1'b1, 4);
        chk("t4_eq", 32'(flags), 32'd0);
        start_test();
        seq = '{0, 101, 0};
        run_seq(16'd0, 1'b1, 12);
        chk("t4_above", 32'(flags), 32'd1);

        // Disabled finder still delays data
        start_test();
        seq = '{0, 300, 0};
        run_seq(16'd7, 1'b0, 4);
        chk("t5_flags", 32'(flags), 32'd0);

        // Reset in the middle of a hold-off
        start_test();
        seq = '{0, 400, 0, 0};
        run_seq(16'd0, 1'b1, 0);
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        do_reset();
        step(16'd500, 16'd1, 1'b1);
        chk("t6_zero0", {15'd0, bus.et_out}, 32'd0);
        step(16'd900, 16'd2, 1'b1);
        chk("t6_zero1", {15'd0, bus.et_out}, 32'd0);
        for (int i = 0; i < 12; i++) step(16'd0, 16'd0, 1'b1);

`ifdef PEAK_CNT_EN
        cnt_clr = 1'b1;
        step(16'd0, 16'd0, 1'b1);
        cnt_clr = 1'b0;
        seq = '{0, 300, 0};
        for (int k = 0; k < 17; k++) run_seq(16'd0, 1'b1, 9);
        chk("cnt_sat", 32'(peak_cnt), 32'd15);
        step(16'd0, 16'd0, 1'b1);
        step(16'd300, 16'd0, 1'b1);
        step(16'd0, 16'd0, 1'b1);
        cnt_clr = 1'b1;
        step(16'd0, 16'd0, 1'b1);
        cnt_clr = 1'b0;
        chk("cnt_clr_pk", 32'(peak_cnt), 32'd0);
        for (int i = 0; i < 10; i++) step(16'd0, 16'd0, 1'b1);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 0) et_min = 16'($urandom_range(50, 250));
`ifdef PEAK_CNT_EN
            cnt_clr = ($urandom_range(0, 49) == 0);
`endif
            step(16'($urandom_range(0, 400)), 16'($urandom), $urandom_range(0, 9) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
